// File: rtl/ro_puf_pair_ctrl.sv
// Ring-oscillator PUF pair controller: select, settle, count, compare.
// Optional margin check enabled by defining RO_PUF_MARGIN_EN.
module ro_puf_pair_ctrl #(
  parameter int CNT_W  = 16,
  parameter int WINDOW = 1024,
  parameter int SETTLE = 4,
  parameter int MARGIN = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [5:0] challenge,
  input  logic       ro_a,
  input  logic       ro_b,
  output logic [2:0] sel_a,
  output logic [2:0] sel_b,
  output logic       ro_en,
  output logic       busy,
  output logic       done,
  output logic       response,
  output logic       err,
  output logic       unstable
);

  localparam int TMAX = (WINDOW > SETTLE) ? WINDOW : SETTLE;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [TW-1:0] WIN_LD = TW'(WINDOW - 1);
  localparam logic [TW-1:0] SET_LD = TW'(SETTLE - 1);
  localparam logic [TW-1:0] T_ONE  = TW'(1);

  localparam logic [CNT_W-1:0] C_MAX = '1;
  localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_SETL = 3'd1;
  localparam logic [2:0] S_CNT  = 3'd2;
  localparam logic [2:0] S_CMP  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;
  localparam logic [2:0] S_ERR  = 3'd5;

  logic [2:0]       state_q, state_d;
  logic [TW-1:0]    tmr_q, tmr_d;
  logic [CNT_W-1:0] cnt_a_q, cnt_a_d;
  logic [CNT_W-1:0] cnt_b_q, cnt_b_d;
  logic [2:0]       sel_a_q, sel_a_d;
  logic [2:0]       sel_b_q, sel_b_d;
  logic             resp_q, resp_d;
  logic             err_q, err_d;
  logic             unst_q, unst_d;
  logic [2:0]       sa_q, sb_q;
  logic             edge_a, edge_b;
  logic             unst_cmp;
  logic             idx_eq;

  // Two flops resolve metastability; the third remembers the last level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa_q <= '0;
      sb_q <= '0;
    end else begin
      sa_q <= {sa_q[1:0], ro_a};
      sb_q <= {sb_q[1:0], ro_b};
    end
  end

  assign edge_a = sa_q[1] & ~sa_q[2];
  assign edge_b = sb_q[1] & ~sb_q[2];
  assign idx_eq = (challenge[2:0] == challenge[5:3]);

`ifdef RO_PUF_MARGIN_EN
  logic [CNT_W:0] diff;

  always_comb begin
    if (cnt_a_q >= cnt_b_q)
      diff = {1'b0, cnt_a_q} - {1'b0, cnt_b_q};
    else
      diff = {1'b0, cnt_b_q} - {1'b0, cnt_a_q};
  end

  assign unst_cmp = (diff < (CNT_W+1)'(MARGIN));
`else
  assign unst_cmp = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    cnt_a_d = cnt_a_q;
    cnt_b_d = cnt_b_q;
    sel_a_d = sel_a_q;
    sel_b_d = sel_b_q;
    resp_d  = resp_q;
    err_d   = err_q;
    unst_d  = unst_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          sel_a_d = challenge[2:0];
          sel_b_d = challenge[5:3];
          cnt_a_d = '0;
          cnt_b_d = '0;
          resp_d  = 1'b0;
          err_d   = idx_eq;
          unst_d  = 1'b0;
          tmr_d   = SET_LD;
          state_d = idx_eq ? S_ERR : S_SETL;
        end
      end
      S_SETL: begin
        if (tmr_q == '0) begin
          tmr_d   = WIN_LD;
          state_d = S_CNT;
        end else begin
          tmr_d = tmr_q - T_ONE;
        end
      end
      S_CNT: begin
        if (edge_a && cnt_a_q != C_MAX)
          cnt_a_d = cnt_a_q + C_ONE;
        if (edge_b && cnt_b_q != C_MAX)
          cnt_b_d = cnt_b_q + C_ONE;
        if (tmr_q == '0)
          state_d = S_CMP;
        else
          tmr_d = tmr_q - T_ONE;
      end
      S_CMP: begin
        resp_d  = (cnt_a_q > cnt_b_q);
        unst_d  = unst_cmp;
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      tmr_q   <= '0;
      cnt_a_q <= '0;
      cnt_b_q <= '0;
      sel_a_q <= '0;
      sel_b_q <= '0;
      resp_q  <= 1'b0;
      err_q   <= 1'b0;
      unst_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      cnt_a_q <= cnt_a_d;
      cnt_b_q <= cnt_b_d;
      sel_a_q <= sel_a_d;
      sel_b_q <= sel_b_d;
      resp_q  <= resp_d;
      err_q   <= err_d;
      unst_q  <= unst_d;
    end
  end

  assign sel_a    = sel_a_q;
  assign sel_b    = sel_b_q;
  assign ro_en    = (state_q == S_SETL) || (state_q == S_CNT);
  assign busy     = ro_en || (state_q == S_CMP);
  assign done     = (state_q == S_DONE) || (state_q == S_ERR);
  assign response = resp_q;
  assign err      = err_q;
  assign unstable = unst_q;

endmodule
